// File: rtl/debounce_fsm.sv
// debounce_fsm: synchronizes a bouncy switch and qualifies each level change
// over 2^N stable cycles, emitting a clean level and a one-cycle rise tick.
module debounce_fsm #(
    parameter int N = 21
) (
    input  logic clk,
    input  logic rst,
    input  logic sw,
    output logic db_level,
    output logic db_tick
);
    // Bit 1 of the encoding is the debounced level, so db_level is a flop output
    localparam logic [1:0] ZERO  = 2'b00;
    localparam logic [1:0] WAIT1 = 2'b01;
    localparam logic [1:0] ONE   = 2'b10;
    localparam logic [1:0] WAIT0 = 2'b11;

    logic         s1_q, s2_q;
    logic [1:0]   state_q, state_d;
    logic [N-1:0] cnt_q, cnt_d;
    logic         tick_q, tick_d;
    logic         cnt_zero;

    assign cnt_zero = cnt_q == '0;
    assign tick_d   = state_q == WAIT1 && s2_q && cnt_zero;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ZERO:
                if (s2_q) begin
                    state_d = WAIT1;
                    cnt_d   = '1;
                end
            WAIT1:
                if (!s2_q)
                    state_d = ZERO;
                else if (!cnt_zero)
                    cnt_d = cnt_q - N'(1);
                else
                    state_d = ONE;
            ONE:
                if (!s2_q) begin
                    state_d = WAIT0;
                    cnt_d   = '1;
                end
            WAIT0:
                if (s2_q)
                    state_d = ONE;
                else if (!cnt_zero)
                    cnt_d = cnt_q - N'(1);
                else
                    state_d = ZERO;
            default:
                state_d = ZERO;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= ZERO;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            s1_q    <= sw;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
        end
    end

    assign db_level = state_q[1];
    assign db_tick  = tick_q;
endmodule

// File: tb/tb_debounce_fsm.sv
// tb_debounce_fsm: directed and random stimulus against a run-length model
// of the debouncer: the level flips after 2^N+1 consecutive opposite samples.
module tb_debounce_fsm;
    localparam int N        = 4;
    localparam int INTERVAL = 2 ** N;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sw  = 1'b0;
    logic db_level, db_tick;

    int checks   = 0;
    int failures = 0;
    int tick_cnt = 0;

    logic m_s1, m_s2, exp_level, exp_tick;
    int   run;

    debounce_fsm #(.N(N)) dut (
        .clk(clk),
        .rst(rst),
        .sw(sw),
        .db_level(db_level),
        .db_tick(db_tick)
    );

    always #5 clk = ~clk;

    // Reference: count consecutive synchronized samples that disagree with the level
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1      <= 1'b0;
            m_s2      <= 1'b0;
            run       <= 0;
            exp_level <= 1'b0;
            exp_tick  <= 1'b0;
        end else begin
            m_s1 <= sw;
            m_s2 <= m_s1;
            if (m_s2 != exp_level && run == INTERVAL) begin
                exp_level <= m_s2;
                exp_tick  <= m_s2;
                run       <= 0;
            end else begin
                exp_tick <= 1'b0;
                run      <= (m_s2 != exp_level) ? run + 1 : 0;
            end
        end
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc(input logic v);
        sw = v;
        @(negedge clk);
        chk("model_level", db_level, exp_level);
        chk("model_tick", db_tick, exp_tick);
        if (db_tick) tick_cnt++;
    endtask

    task automatic hold(input logic v, input int n);
        for (int i = 0; i < n; i++) cyc(v);
    endtask

    // Holds v for 20 edges and checks the fixed edge-19 latency directly
    task automatic settle(input string tag, input logic v);
        for (int k = 1; k <= 20; k++) begin
            cyc(v);
            if (k == 18) chk({tag, "_l18"}, db_level, ~v);
            if (k == 19) begin
                chk({tag, "_l19"}, db_level, v);
                chk({tag, "_t19"}, db_tick, v);
            end
            if (k == 20) chk({tag, "_t20"}, db_tick, 1'b0);
        end
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        chk({tag, "_lvl"}, db_level, 1'b0);
        chk({tag, "_tick"}, db_tick, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    int t0;

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_level", db_level, 1'b0);
        chk("reset_tick", db_tick, 1'b0);
        rst = 1'b0;

        settle("press", 1'b1);
        hold(1'b1, 5);
        chk("press_hold", db_level, 1'b1);

        settle("release", 1'b0);
        hold(1'b0, 5);

        t0 = tick_cnt;
        for (int b = 0; b < 4; b++) begin
            hold(b[0] ? 1'b0 : 1'b1, 3);
            chk("bounce_level", db_level, 1'b0);
        end
        chk("bounce_noticks", 1'(tick_cnt != t0), 1'b0);
        settle("bounce", 1'b1);

        hold(1'b0, 5);
        hold(1'b1, 20);
        chk("glitch_one", db_level, 1'b1);
        settle("release2", 1'b0);
        t0 = tick_cnt;
        hold(1'b1, 10);
        hold(1'b0, 20);
        chk("glitch_zero", db_level, 1'b0);
        chk("glitch_noticks", 1'(tick_cnt != t0), 1'b0);

        t0 = tick_cnt;
        for (int r = 0; r < 3; r++) begin
            hold(1'b1, 25);
            hold(1'b0, 25);
        end
        chk("repeat_three", 1'(tick_cnt - t0 == 3), 1'b1);

        hold(1'b1, 8);
        async_reset("rst_wait1");
        settle("after_rst", 1'b1);
        hold(1'b1, 3);
        async_reset("rst_one");
        sw = 1'b0;
        hold(1'b0, 5);

        for (int i = 0; i < 60; i++) begin
            hold(1'($urandom_range(0, 1)), $urandom_range(1, 25));
            if ($urandom_range(0, 19) == 0) async_reset("rand_rst");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/debounce_fsm.md
Name: debounce_fsm

Overview:
- Debounces one mechanical switch/pushbutton input.
- Outputs a clean debounced level and a one-cycle tick on each debounced rising edge.
- Sits between board key pins and user logic; the two-ball video demo uses one instance per key, consuming `db_tick` only.
- Explicit 4-state FSM plus a down-counter measures the stability interval.

Parameters:
- `N`, default 21: counter width. Stability interval is 2^N clk cycles (about 42 ms at 50 MHz). Benches use `N=4`.

Ports:
- `clk`, input, 1: system clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `sw`, input, 1: raw, bouncy, asynchronous switch level.
- `db_level`, output, 1: debounced switch level, registered.
- `db_tick`, output, 1: single-cycle pulse on a debounced 0->1 transition, registered.

Behaviour:
- **Reset:** `rst`=1 asynchronously forces:
  - synchronizer flops = 0
  - state = ZERO
  - counter = 0
  - `db_level` = 0, `db_tick` = 0
  - Reset mid-count discards progress; after release, the full interval is required again.
- **Synchronizer:** two-flop chain `sw -> s1 -> s2`. `sw_s` = s2. FSM sees only `sw_s`, which adds 2 cycles of latency.
- **Counter:** N-bit unsigned. Loaded with all-ones (2^N-1); decrements by 1. It never wraps: the decrement only happens when it is nonzero.
- **States:** `db_level` = 1 in ONE and WAIT0, 0 in ZERO and WAIT1.
  - **ZERO:**
    - `sw_s`=1 -> load counter = 2^N-1, go WAIT1.
    - else stay.
  - **WAIT1:**
    - `sw_s`=0 -> go ZERO (abort, no tick).
    - `sw_s`=1 and counter != 0 -> decrement, stay.
    - `sw_s`=1 and counter == 0 -> go ONE; `db_tick` is 1 in the first cycle ONE is held.
  - **ONE:**
    - `sw_s`=0 -> load counter = 2^N-1, go WAIT0.
    - else stay.
  - **WAIT0:**
    - `sw_s`=1 -> go ONE (abort, no tick).
    - `sw_s`=0 and counter != 0 -> decrement, stay.
    - `sw_s`=0 and counter == 0 -> go ZERO.
  - Illegal state encodings -> ZERO.
- **db_tick:** register loaded with (state==WAIT1 && `sw_s` && counter==0). It is high exactly one cycle, coincident with the first cycle `db_level`=1. Never high on a falling transition, never high two consecutive cycles.
- **Latency:** with `sw` stable from before rising edge 1:
  - `db_level` changes after edge 2^N+3 (N=4: edge 19).
  - Breakdown: 2 synchronizer + 1 load + 2^N-1 decrements + 1 transition.
- **Glitch rejection:** any opposite-level `sw_s` sample during WAIT1/WAIT0 returns to the prior stable state. The next qualifying edge reloads the counter fully; there is no partial credit.
- `db_level` and `db_tick` are pure flop outputs, with no combinational path from `sw`.

Test Plan:
1. **Reset:** assert `rst` mid-simulation while in WAIT1 -> `db_level`=0, `db_tick`=0 immediately (asynchronous). After release with `sw`=1 held, `db_level` rises at edge 19 (N=4), not earlier.
2. **Clean press, N=4:** `sw` 0->1 before edge 1, held -> `db_level`=0 through edge 18; `db_level`=1 and `db_tick`=1 after edge 19; `db_tick`=0 after edge 20; `db_level` stays 1.
3. **Bouncy press:** `sw` toggles 1,0,1,0 every 3 cycles, then stays 1 -> no `db_tick` during bounce; exactly one `db_tick` at 19 edges after the final 0->1; `db_level`=0 throughout the bounce.
4. **Release:** from ONE, `sw` 1->0 held -> `db_level` falls after edge 19; `db_tick` stays 0 the whole time.
5. **Short glitch:** in ONE, `sw`=0 for 5 cycles then back to 1 -> `db_level` stays 1, no `db_tick`. Likewise, in ZERO a 10-cycle high pulse -> `db_level` stays 0, no `db_tick`.
6. **Repeated presses:** three clean press/release cycles, each level held ≥25 cycles -> exactly three `db_tick` pulses, each one cycle wide, each aligned with a `db_level` rise.
